// File: rtl/atomic_pkg.sv
// Shared types for the atomic-memory-operation sequencer: funct5 codes,
// FSM states and the word-granule constant.
package atomic_pkg;

  localparam int XLEN        = 32;
  localparam int AMO_GRANULE = 2;

  typedef logic [XLEN-1:0] t_xlen;

  typedef enum logic [4:0] {
    F_AMOADD  = 5'b00000,
    F_AMOSWAP = 5'b00001,
    F_LR      = 5'b00010,
    F_SC      = 5'b00011,
    F_AMOXOR  = 5'b00100,
    F_AMOOR   = 5'b01000,
    F_AMOAND  = 5'b01100,
    F_AMOMIN  = 5'b10000,
    F_AMOMAX  = 5'b10100,
    F_AMOMINU = 5'b11000,
    F_AMOMAXU = 5'b11100
  } e_atomic_funct5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_RESP,
    S_ERR
  } e_amo_state;

  function automatic logic is_legal_funct5(input logic [4:0] f);
    logic ok;
    case (f)
      F_AMOADD, F_AMOSWAP, F_LR, F_SC, F_AMOXOR, F_AMOOR, F_AMOAND,
      F_AMOMIN, F_AMOMAX, F_AMOMINU, F_AMOMAXU: ok = 1'b1;
      default:                                  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/amo_alu.sv
// Combinational read-modify-write operator for the AMO family.
// Non-AMO codes fall through to rs2, which is the SC store value.
module amo_alu #(
  parameter int XLEN = 32
) (
  input  logic [4:0]      funct5,
  input  logic [XLEN-1:0] old,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] amo_new
);
  import atomic_pkg::*;

  logic lt_s;
  logic lt_u;

  assign lt_s = $signed(old) < $signed(rs2);
  assign lt_u = old < rs2;

  always_comb begin
    amo_new = rs2;
    case (funct5)
      F_AMOADD:  amo_new = old + rs2;
      F_AMOXOR:  amo_new = old ^ rs2;
      F_AMOAND:  amo_new = old & rs2;
      F_AMOOR:   amo_new = old | rs2;
      F_AMOMIN:  amo_new = lt_s ? old : rs2;
      F_AMOMAX:  amo_new = lt_s ? rs2 : old;
      F_AMOMINU: amo_new = lt_u ? old : rs2;
      F_AMOMAXU: amo_new = lt_u ? rs2 : old;
      default:   amo_new = rs2;
    endcase
  end

endmodule

// File: rtl/amo_sequencer.sv
// LR/SC/AMO sequencer: one op at a time, read/modify/write over a single
// memory port, owns the LR/SC reservation and returns the rd value.
module amo_sequencer #(
  parameter int XLEN          = 32,
  parameter int RESV_GRAN_LSB = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      req_funct5,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [4:0]      req_rd,
  input  logic            resv_clear,
  input  logic            st_snoop_valid,
  input  logic [XLEN-1:0] st_snoop_addr,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rsp_valid,
  output logic [4:0]      rsp_rd,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_err
);
  import atomic_pkg::*;

  e_amo_state      state;
  logic [4:0]      op_funct5;
  logic [XLEN-1:0] op_rs2;
  logic [XLEN-1:0] amo_new;
  logic            resv_valid;
  logic [XLEN-1:0] resv_addr;

  function automatic logic same_word(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    return ((a ^ b) >> RESV_GRAN_LSB) == '0;
  endfunction

  logic accept, req_bad, sc_hit;
  logic resv_set, resv_kill;

  assign accept  = req_valid && req_ready;
  assign req_bad = (req_addr[AMO_GRANULE-1:0] != '0) || !is_legal_funct5(req_funct5);
  assign sc_hit  = resv_valid && same_word(req_addr, resv_addr);

  amo_alu #(.XLEN(XLEN)) u_alu (
    .funct5  (op_funct5),
    .old     (mem_rdata),
    .rs2     (op_rs2),
    .amo_new (amo_new)
  );

  // rsp_data doubles as the result register between capture and response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      op_funct5 <= '0;
      op_rs2    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rd    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_funct5 <= req_funct5;
            op_rs2    <= req_rs2;
            mem_addr  <= req_addr;
            rsp_rd    <= req_rd;
            req_ready <= 1'b0;
            if (req_bad) begin
              state     <= S_ERR;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
            end else if (req_funct5 == F_SC) begin
              if (sc_hit) begin
                state     <= S_WR_REQ;
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_wdata <= req_rs2;
                rsp_data  <= '0;
              end else begin
                state     <= S_RESP;
                rsp_valid <= 1'b1;
                rsp_data  <= XLEN'(1);
              end
            end else begin
              state   <= S_RD_REQ;
              mem_req <= 1'b1;
              mem_we  <= 1'b0;
            end
          end
        end
        S_RD_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (mem_rvalid) begin
            rsp_data <= mem_rdata;
            if (op_funct5 == F_LR) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
            end else begin
              state     <= S_WR_REQ;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_wdata <= amo_new;
            end
          end
        end
        S_WR_REQ: begin
          if (mem_gnt) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            state     <= S_RESP;
            rsp_valid <= 1'b1;
          end
        end
        S_RESP, S_ERR: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_data  <= '0;
          rsp_rd    <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A set from an LR read takes priority over any same-cycle clear source.
  assign resv_set  = (state == S_RD_WAIT) && mem_rvalid && (op_funct5 == F_LR);
  assign resv_kill = resv_clear
                  || (accept && !req_bad && (req_funct5 == F_SC))
                  || (st_snoop_valid && same_word(st_snoop_addr, resv_addr))
                  || ((state == S_WR_REQ) && mem_gnt && (op_funct5 != F_SC)
                      && same_word(mem_addr, resv_addr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resv_valid <= 1'b0;
      resv_addr  <= '0;
    end else if (resv_set) begin
      resv_valid <= 1'b1;
      resv_addr  <= mem_addr;
    end else if (resv_kill) begin
      resv_valid <= 1'b0;
    end
  end

endmodule

// File: doc/amo_sequencer.md
Name: amo_sequencer

Overview:
Multi-cycle controller for the A-extension (opcode ATOMIC). It accepts one LR/SC/AMO operation at a time from the execute stage and sequences the read, modify and write accesses on a single data-memory port. It owns the LR/SC reservation and returns the rd writeback value. It sits between the execute stage and the data-memory arbiter, beside the load/store unit.

Parameters:
XLEN, 32, data and address width
RESV_GRAN_LSB, 2, low address bits ignored in the reservation match (word granule)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  atomic op offered
req_ready  out  1  high only in IDLE
req_funct5  in  5  e_atomic_funct5 code
req_addr  in  XLEN  rs1 (effective address)
req_rs2  in  XLEN  store/operand value
req_rd  in  5  destination register
resv_clear  in  1  trap or context switch; drops the reservation
st_snoop_valid  in  1  another agent/LSU store committed
st_snoop_addr  in  XLEN  address of that store
mem_req  out  1  memory request; held until mem_gnt
mem_we  out  1  1=write, 0=read
mem_addr  out  XLEN  word address (req_addr)
mem_wdata  out  XLEN  write data
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid (earliest: cycle after gnt)
mem_rdata  in  XLEN  read data
rsp_valid  out  1  one-cycle writeback pulse
rsp_rd  out  5  destination register
rsp_data  out  XLEN  rd value
rsp_err  out  1  misaligned address or illegal funct5

Behaviour:
- Reset values: all outputs 0 except req_ready=1. State=IDLE; reservation invalid. An asserted rst mid-operation aborts immediately; mem_req drops asynchronously and no response is issued.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP, ERR.
- IDLE: on req_valid&&req_ready, latch funct5/addr/rs2/rd.
  - addr[1:0]!=0 or funct5 not in enum -> ERR.
  - LR or AMO* -> RD_REQ.
  - SC with reservation valid and addr[XLEN-1:RESV_GRAN_LSB] match -> WR_REQ, result=0.
  - SC otherwise -> RESP, result=1, no memory access.
- RD_REQ: mem_req=1, mem_we=0. On mem_gnt -> RD_WAIT.
- RD_WAIT: on mem_rvalid, capture old=mem_rdata, and:
  - LR: set the reservation to addr, result=old, -> RESP.
  - AMO: result=old, -> WR_REQ.
- WR_REQ: mem_req=1, mem_we=1. mem_wdata=rs2 for SC, amo_alu(old, rs2) for AMO. On mem_gnt -> RESP. A write completes on grant; there is no write ack.
- RESP: rsp_valid=1 for exactly one cycle with rsp_rd and rsp_data=result, then -> IDLE. req_ready=0.
- ERR: rsp_valid=1, rsp_err=1, rsp_data=0 for one cycle, then -> IDLE.
- AMO arithmetic, XLEN-bit with wrap-around add:
  - AMOSWAP=rs2; AMOADD=old+rs2.
  - AMOXOR/AND/OR are bitwise.
  - MIN/MAX use signed compare; MINU/MAXU use unsigned compare.
- Reservation:
  - Every executed SC clears it, success or fail.
  - resv_clear clears it.
  - A matching st_snoop_valid word clears it.
  - An AMO write to the reserved word clears it.
  - Simultaneous set (LR rvalid) and clear in the same cycle: set wins.
  - resv_clear never aborts an in-flight op.
- Minimum latency, with gnt in the request cycle and rvalid one cycle later:
  - LR: accept at T0, response at T3.
  - AMO: response at T4.
  - Failed SC: response at T1.
  - Successful SC: response at T2.
- mem_addr and mem_wdata are stable while mem_req=1.

Decomposition:
- Shared package (instructions_pkg or a new atomic_pkg):
  - e_amo_state enum.
  - AMO_GRANULE constant.
  - Reuse of e_atomic_funct5, XLEN and t_xlen.
- One combinational sub-module, amo_alu: inputs funct5, old, rs2; output new.

Test Plan:
- LR 0x100 (mem[0x100]=0xDEADBEEF), then SC 0x100 rs2=0x5 -> LR rsp_data=0xDEADBEEF; SC rsp_data=0 and write 0x5; a second SC returns 1 with no mem_req.
- LR 0x200, then st_snoop 0x202, then SC 0x200 -> SC rsp_data=1, no write issued.
- AMOADD 0x40 with old=0xFFFFFFFF, rs2=2 -> write 0x00000001, rsp_data=0xFFFFFFFF.
- AMOMIN vs AMOMINU with old=0x80000000, rs2=1 -> writes 0x80000000 and 0x00000001 respectively.
- AMOSWAP to 0x13 -> ERR: rsp_err=1, rsp_data=0, no mem_req. Illegal funct5 5'b00101 gives the same response.
- mem_gnt delayed 3 cycles and rst asserted in RD_WAIT -> mem_req stays stable while waiting; after reset the block is in IDLE with req_ready=1, no rsp_valid, and the reservation invalid.
